// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and helpers for the timing generator.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Raw decode bits carried through the delay line; all-zero means idle/blank.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous reset; DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en) begin
          stage_q[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync/active decode, latency-matching delay
// line, registered output stage and line/frame start strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pix_en,
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  output logic [CNT_W-1:0]   o_hcounter,
  output logic [CNT_W-1:0]   o_vcounter,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, v_q;
  logic             h_wrap, v_wrap;
  int unsigned      h_u, v_u;
  sync_t            raw, dly;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Decode in 32-bit space so sync end == 2**CNT_W cannot overflow the compare.
  assign h_u = 32'(h_q);
  assign v_u = 32'(v_q);

  always_comb begin
    raw     = '0;
    raw.hs  = (h_u >= H_ACTIVE + H_FP) && (h_u < H_ACTIVE + H_FP + H_SYNC);
    raw.vs  = (v_u >= V_ACTIVE + V_FP) && (v_u < V_ACTIVE + V_FP + V_SYNC);
    raw.act = (h_u < H_ACTIVE) && (v_u < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (i_pix_en) begin
      h_q <= h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_q <= v_wrap ? '0 : v_q + 1'b1;
    end
  end

  vga_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ('0)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (i_pix_en),
    .d   (raw),
    .q   (dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hsync  <= ~H_POL;
      o_vsync  <= ~V_POL;
      o_active <= 1'b0;
      o_red    <= '0;
      o_green  <= '0;
      o_blue   <= '0;
    end else if (i_pix_en) begin
      o_hsync  <= dly.hs ? H_POL : ~H_POL;
      o_vsync  <= dly.vs ? V_POL : ~V_POL;
      o_active <= dly.act;
      o_red    <= dly.act ? i_red   : '0;
      o_green  <= dly.act ? i_green : '0;
      o_blue   <= dly.act ? i_blue  : '0;
    end
  end

  // Strobes re-evaluate every clk so they stay one clk wide regardless of pix_en rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= i_pix_en && h_wrap;
      o_frame_start <= i_pix_en && h_wrap && v_wrap;
    end
  end

  assign o_hcounter = h_q;
  assign o_vcounter = v_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small 8x6 configuration with PIPE_DLY=2 and a default 640x480 instance
// with PIPE_DLY=0.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small configuration
  logic       rst, pix_en;
  logic [3:0] i_red, i_green, i_blue;
  logic [9:0] hcnt, vcnt;
  logic       hsync, vsync, active, line_start, frame_start;
  logic [3:0] o_red, o_green, o_blue;

  // Default 640x480 configuration
  logic       rst2;
  logic [9:0] hcnt2, vcnt2;
  logic       hsync2, vsync2, active2, line2, frame2;
  logic [3:0] red2, green2, blue2;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .PIPE_DLY (2)
  ) u_small (
    .clk           (clk),
    .rst           (rst),
    .i_pix_en      (pix_en),
    .i_red         (i_red),
    .i_green       (i_green),
    .i_blue        (i_blue),
    .o_hcounter    (hcnt),
    .o_vcounter    (vcnt),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_active      (active),
    .o_line_start  (line_start),
    .o_frame_start (frame_start),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue)
  );

  vga_timing_gen #(
    .PIPE_DLY (0)
  ) u_big (
    .clk           (clk),
    .rst           (rst2),
    .i_pix_en      (1'b1),
    .i_red         (4'h0),
    .i_green       (4'h0),
    .i_blue        (4'h0),
    .o_hcounter    (hcnt2),
    .o_vcounter    (vcnt2),
    .o_hsync       (hsync2),
    .o_vsync       (vsync2),
    .o_active      (active2),
    .o_line_start  (line2),
    .o_frame_start (frame2),
    .o_red         (red2),
    .o_green       (green2),
    .o_blue        (blue2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clk: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " h"}, 32'(hcnt), 0);
    check_val({tag, " v"}, 32'(vcnt), 0);
    check_val({tag, " hsync"}, 32'(hsync), 1);
    check_val({tag, " vsync"}, 32'(vsync), 1);
    check_val({tag, " active"}, 32'(active), 0);
    check_val({tag, " red"}, 32'(o_red), 0);
    check_val({tag, " blue"}, 32'(o_blue), 0);
    check_val({tag, " line"}, 32'(line_start), 0);
    check_val({tag, " frame"}, 32'(frame_start), 0);
  endtask

  initial begin
    int n_line, n_frame, ticks, j, hj, vj;
    logic exp_hs, exp_vs, exp_act;

    rst    = 1'b1;
    rst2   = 1'b1;
    pix_en = 1'b1;
    i_red   = 4'hF;
    i_green = 4'hA;
    i_blue  = 4'h3;
    @(negedge clk);
    step();
    step();
    check_reset_state("rst");

    // Free run from reset: wrap, syncs, blanking and strobes over more than one frame.
    rst = 1'b0;
    n_line  = 0;
    n_frame = 0;
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) step();
      j = k - 3;
      if (j < 0) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_act = 1'b0;
      end else begin
        hj = j % 8;
        vj = (j / 8) % 6;
        exp_hs  = !(hj >= 5 && hj <= 6);
        exp_vs  = !(vj == 4);
        exp_act = (hj < 4) && (vj < 3);
      end
      check_val($sformatf("run h k=%0d", k), 32'(hcnt), 32'(k % 8));
      check_val($sformatf("run v k=%0d", k), 32'(vcnt), 32'((k / 8) % 6));
      check_val($sformatf("run hsync k=%0d", k), 32'(hsync), 32'(exp_hs));
      check_val($sformatf("run vsync k=%0d", k), 32'(vsync), 32'(exp_vs));
      check_val($sformatf("run active k=%0d", k), 32'(active), 32'(exp_act));
      check_val($sformatf("run red k=%0d", k), 32'(o_red), exp_act ? 32'hF : 32'h0);
      check_val($sformatf("run blue k=%0d", k), 32'(o_blue), exp_act ? 32'h3 : 32'h0);
      check_val($sformatf("run line k=%0d", k), 32'(line_start),
                32'(k > 0 && k % 8 == 0));
      check_val($sformatf("run frame k=%0d", k), 32'(frame_start),
                32'(k > 0 && k % 48 == 0));
      if (k >= 1 && k <= 48) begin
        n_line  += int'(line_start);
        n_frame += int'(frame_start);
      end
    end
    check_val("line count", 32'(n_line), 6);
    check_val("frame count", 32'(n_frame), 1);

    // pix_en every other clk: counters advance at half rate, strobes stay one clk wide.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ticks = 0;
    for (int c = 0; c < 40; c++) begin
      pix_en = (c % 2 == 0);
      step();
      if (pix_en) ticks++;
      check_val($sformatf("half h c=%0d", c), 32'(hcnt), 32'(ticks % 8));
      check_val($sformatf("half v c=%0d", c), 32'(vcnt), 32'((ticks / 8) % 6));
      check_val($sformatf("half line c=%0d", c), 32'(line_start),
                32'(pix_en && ticks % 8 == 0));
      check_val($sformatf("half frame c=%0d", c), 32'(frame_start), 0);
    end
    pix_en = 1'b0;
    step();
    step();
    check_val("freeze h", 32'(hcnt), 32'(ticks % 8));
    check_val("freeze line", 32'(line_start), 0);
    pix_en = 1'b1;

    // Mid-frame reset at h=5, v=2.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 21; k++) step();
    check_val("pre-rst h", 32'(hcnt), 5);
    check_val("pre-rst v", 32'(vcnt), 2);
    rst = 1'b1;
    step();
    check_reset_state("midrst");
    rst = 1'b0;
    step();
    check_val("restart h", 32'(hcnt), 1);
    check_val("restart v", 32'(vcnt), 0);
    check_val("restart frame", 32'(frame_start), 0);
    check_val("restart line", 32'(line_start), 0);

    // Default 640x480 with no pipeline delay.
    rst2 = 1'b0;
    for (int k = 0; k <= 1457; k++) begin
      if (k > 0) step();
      case (k)
        0: begin
          check_val("big h0", 32'(hcnt2), 0);
          check_val("big hs0", 32'(hsync2), 1);
        end
        656: begin
          check_val("big h656", 32'(hcnt2), 656);
          check_val("big hs656", 32'(hsync2), 1);
        end
        657: check_val("big hs657", 32'(hsync2), 0);
        752: check_val("big hs752", 32'(hsync2), 0);
        753: check_val("big hs753", 32'(hsync2), 1);
        800: begin
          check_val("big h800", 32'(hcnt2), 0);
          check_val("big v800", 32'(vcnt2), 1);
          check_val("big line800", 32'(line2), 1);
          check_val("big frame800", 32'(frame2), 0);
          check_val("big vs800", 32'(vsync2), 1);
        end
        801: check_val("big line801", 32'(line2), 0);
        1456: begin
          check_val("big h1456", 32'(hcnt2), 656);
          check_val("big hs1456", 32'(hsync2), 1);
        end
        1457: check_val("big hs1457", 32'(hsync2), 0);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
